mc_memsys: RTL
==============

# mc_memsys

Unified instruction/data memory subsystem for the multicycle MIPS core. It sits directly downstream of the core's memory-control outputs (`iord`, `memwrite`, `irwrite`, `pc`, `aluout`, `writedata`) and returns the registered `instr` and `readdata` words the core consumes. It also provides:
- a handshaked preload port, so a bench or boot loader can fill memory;
- a sticky misalignment flag;
- an optional memory-mapped output register.

## Interface
- `DEPTH`, default 256: RAM size in 32-bit words; must be a power of two.
- `MMIO_ADDR`, default 32'hFFFF_FFFC: byte address of the output register.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: **asynchronous, active-low** reset.
- `iord`  in  1: 0 = address is `pc`, 1 = address is `aluout`.
- `memwrite`  in  1: core store strobe.
- `irwrite`  in  1: load instruction register.
- `pc`  in  32: fetch byte address.
- `aluout`  in  32: data byte address.
- `writedata`  in  32: store data.
- `instr`  out  32: instruction register (IR).
- `readdata`  out  32: memory data register (MDR).
- `ld_valid`  in  1: preload request.
- `ld_addr`  in  32: preload byte address.
- `ld_data`  in  32: preload word.
- `ld_ready`  out  1: preload accepted this cycle.
- `misalign`  out  1: sticky misaligned-access flag.
- `mmio_out`  out  32: output register (present only with the macro; see Configuration).
- `mmio_strobe`  out  1: one-cycle pulse on each write to the output register.

## Operation
- Effective address: `addr = iord ? aluout : pc`. Word index is `addr[log2(DEPTH)+1:2]`; upper bits are ignored, so accesses wrap modulo DEPTH words.
- RAM read is combinational: `rd = mem[index]`.
- MDR loads `rd` every cycle, unconditionally.
- IR loads `mem[pc index]` when `irwrite` = 1, independent of `iord`. Otherwise it holds.
- Core store: when `memwrite` = 1 and `aluout` ≠ `MMIO_ADDR`, then `mem[aluout index] <= writedata`. The store is keyed on `aluout` regardless of `iord`.
- Output-register store: when `memwrite` = 1 and `aluout` = `MMIO_ADDR`:
  - `mmio_out <= writedata`;
  - `mmio_strobe` = 1 for the next cycle only;
  - RAM is unchanged.
- Output-register read: a read with `iord` = 1 and `aluout` = `MMIO_ADDR` returns `mmio_out` through MDR, not RAM.
- Preload:
  - `ld_ready = ld_valid & ~memwrite` (combinational).
  - On the edge where `ld_ready` = 1, `mem[ld_addr index] <= ld_data`.
  - A core store in the same cycle wins; the preload stalls until `memwrite` drops.
  - The requester holds `ld_addr`/`ld_data` stable while `ld_valid` = 1 and `ld_ready` = 0.
- Misalignment: `misalign` sets on any edge where either condition holds:
  - `memwrite` = 1 and `aluout[1:0]` ≠ 0;
  - `irwrite` = 1 and `pc[1:0]` ≠ 0.
  
  It clears only on reset. A misaligned access still executes with the low bits dropped.
- No internal FSM stages: it is a registered memory with one arbitration rule.

## Timing
- Reset values: `instr` = 0, `readdata` = 0, `mmio_out` = 0, `mmio_strobe` = 0, `misalign` = 0. RAM contents are not reset.
- Reset asserted mid-operation: registers clear immediately (asynchronous). A write on an edge coincident with reset assertion is discarded.
- Read latency: data at address A in cycle N appears on `readdata` after edge N+1.
- IR latency: `instr` is valid after the `irwrite` edge.
- Read-during-write to the same word: MDR/IR capture the old value; the new value is visible one cycle later.
- Preload and core read of the same word in the same cycle: the read returns the old value.

## Configuration
- `MC_MEMSYS_MMIO_EN` defined:
  - the output register, `mmio_out`, `mmio_strobe` and the `MMIO_ADDR` decode are compiled in.
- `MC_MEMSYS_MMIO_EN` undefined:
  - the `mmio_out` and `mmio_strobe` ports do not exist;
  - `MMIO_ADDR` is treated as an ordinary RAM address (wraps into RAM);
  - all other behaviour is unchanged.

## Structure
- Shared package `common.svh` holds:
  - the existing `u1`/`u2`/`u32` typedefs;
  - `MC_MMIO_ADDR_DEFAULT`;
  - `MC_MEM_DEPTH_DEFAULT`.
- One natural sub-module, `mc_ram`: a DEPTH×32 array with one combinational read port, one fetch read port and one write port. `mc_memsys` owns arbitration, IR, MDR, MMIO and the flag.

## Test plan
- **Preload then fetch:** preload `mem[0]` = 32'h2002_0005 with a clean handshake (`ld_ready` = 1 on the first cycle). Then `pc` = 0, `irwrite` = 1 → `instr` = 32'h2002_0005 after one edge.
- **Store/load round-trip:** `memwrite` = 1, `aluout` = 32'h54, `writedata` = 32'h0000_0007. Next cycle `iord` = 1, `aluout` = 32'h54 → `readdata` = 7 one edge later. The read-during-write cycle returns the old value.
- **Preload collision:** `ld_valid` = 1 in the same cycle as `memwrite` = 1 → `ld_ready` = 0, core word written. Next cycle `ld_ready` = 1 and the preload lands.
- **MMIO (macro on):** store 32'hDEAD_BEEF to 32'hFFFF_FFFC → `mmio_out` = 32'hDEAD_BEEF, `mmio_strobe` high for exactly one cycle, no RAM word changed. A readback via `iord` returns 32'hDEAD_BEEF.
- **Misalignment:** `memwrite` with `aluout` = 32'h0000_0042 → `misalign` = 1 and stays 1. The write lands at word 16.
- **Async reset:** pulse `reset` low mid-cycle → `instr`, `readdata`, `mmio_out`, `misalign` read 0 before the next edge. RAM still holds the preloaded data.

Source files
------------

// File: rtl/mc_memsys_pkg.sv
// mc_memsys_pkg: shared types and defaults for the mc_memsys memory subsystem.
//   u1 / u2 / u32          : scalar, 2-bit and 32-bit logic typedefs
//   MC_MMIO_ADDR_DEFAULT   : default byte address of the memory-mapped output register
//   MC_MEM_DEPTH_DEFAULT   : default RAM depth in 32-bit words (power of two)
package mc_memsys_pkg;

  typedef logic        u1;
  typedef logic [1:0]  u2;
  typedef logic [31:0] u32;

  localparam u32 MC_MMIO_ADDR_DEFAULT = 32'hFFFF_FFFC;
  localparam int MC_MEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/mc_memsys_ram.sv
// mc_ram: DEPTH x 32 word array, no reset on contents.
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational data read port
//   faddr/fdata    : combinational fetch read port
// Reads return the pre-edge contents, so a same-cycle write is seen one cycle later.
module mc_ram
  import mc_memsys_pkg::*;
#(
  parameter int DEPTH = MC_MEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  u32            wdata,
  input  logic [AW-1:0] raddr,
  output u32            rdata,
  input  logic [AW-1:0] faddr,
  output u32            fdata
);

  u32 mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
  assign fdata = mem_q[faddr];

endmodule

// File: rtl/mc_memsys.sv
// mc_memsys: unified instruction/data memory for the multicycle MIPS core.
//   clk, reset (async, active-low)
//   core side : iord, memwrite, irwrite, pc, aluout, writedata -> instr (IR), readdata (MDR)
//   preload   : ld_valid, ld_addr, ld_data -> ld_ready (core stores take priority)
//   status    : misalign (sticky until reset)
//   MMIO      : mmio_out, mmio_strobe, only when MC_MEMSYS_MMIO_EN is defined;
//               otherwise MMIO_ADDR is an ordinary (wrapping) RAM address.
module mc_memsys
  import mc_memsys_pkg::*;
#(
  parameter int DEPTH     = MC_MEM_DEPTH_DEFAULT,
  parameter u32 MMIO_ADDR = MC_MMIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iord,
  input  logic        memwrite,
  input  logic        irwrite,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] instr,
  output logic [31:0] readdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        misalign
`ifdef MC_MEMSYS_MMIO_EN
  ,
  output logic [31:0] mmio_out,
  output logic        mmio_strobe
`endif
);

  localparam int AW = $clog2(DEPTH);

  u32            addr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] fetch_idx;
  u32            rd_data;
  u32            fetch_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  u32            ram_wdata;
  logic          mmio_wr;
  logic          mmio_rd;

  u32 instr_d, instr_q;
  u32 readdata_d, readdata_q;
  u1  misalign_d, misalign_q;
  u32 mmio_out_d, mmio_out_q;
  u1  mmio_strobe_d, mmio_strobe_q;

  always_comb begin
    addr      = iord ? aluout : pc;
    rd_idx    = addr[AW+1:2];
    fetch_idx = pc[AW+1:2];

`ifdef MC_MEMSYS_MMIO_EN
    mmio_wr = memwrite & (aluout == MMIO_ADDR);
    mmio_rd = iord & (aluout == MMIO_ADDR);
`else
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
`endif

    ld_ready = ld_valid & ~memwrite;

    // Single write port: a core store owns it whenever memwrite is high (even
    // when the store is diverted to MMIO), which is what stalls the preload.
    // Gating with reset drops a write on an edge that coincides with reset.
    ram_we    = reset & (memwrite ? ~mmio_wr : ld_valid);
    ram_waddr = memwrite ? aluout[AW+1:2] : ld_addr[AW+1:2];
    ram_wdata = memwrite ? writedata : ld_data;

    readdata_d = mmio_rd ? mmio_out_q : rd_data;
    instr_d    = irwrite ? fetch_data : instr_q;
    misalign_d = misalign_q
               | (memwrite & (aluout[1:0] != 2'b00))
               | (irwrite & (pc[1:0] != 2'b00));

    mmio_out_d    = mmio_wr ? writedata : mmio_out_q;
    mmio_strobe_d = mmio_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q       <= '0;
      readdata_q    <= '0;
      misalign_q    <= 1'b0;
      mmio_out_q    <= '0;
      mmio_strobe_q <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      readdata_q    <= readdata_d;
      misalign_q    <= misalign_d;
      mmio_out_q    <= mmio_out_d;
      mmio_strobe_q <= mmio_strobe_d;
    end
  end

  mc_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_idx),
    .rdata (rd_data),
    .faddr (fetch_idx),
    .fdata (fetch_data)
  );

  assign instr    = instr_q;
  assign readdata = readdata_q;
  assign misalign = misalign_q;

`ifdef MC_MEMSYS_MMIO_EN
  assign mmio_out    = mmio_out_q;
  assign mmio_strobe = mmio_strobe_q;
  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
`else
  // Address bits above the RAM index are ignored so accesses wrap.
  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], addr[1:0], ld_addr[31:AW+2], ld_addr[1:0],
                         MMIO_ADDR, mmio_out_q, mmio_strobe_q};
`endif

endmodule
